// File: rtl/rmii_rx_frame_ctrl.sv
// Frame-level RMII receive controller: MAC filter, length/FCS verdict, single-frame buffer handoff.
// Define RMII_RX_CRC_CHECK_EN to build the FCS checker; otherwise only length and filter decide.
//
// state   | meaning
// IDLE    | waiting for rx_busy to rise
// RECV    | writing bytes of a frame into the buffer, filtering on the first 6 bytes
// DISCARD | ignoring the rest of a dropped, overflowed or filtered frame
// CHECK   | one-cycle length/FCS verdict, then back to IDLE
module rmii_rx_frame_ctrl #(
    parameter int          ADDR_W   = 11,
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter int          MIN_LEN  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    input  logic              rx_busy,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              frm_valid,
    output logic [ADDR_W:0]   frm_len,
    input  logic              frm_ack,
    output logic              crc_err,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {IDLE, RECV, DISCARD, CHECK} state_t;

    localparam logic [ADDR_W:0] BUF_SIZE  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] MIN_LEN_W = (ADDR_W+1)'(MIN_LEN);
    localparam logic [ADDR_W:0] HDR_LEN   = (ADDR_W+1)'(6);
    localparam logic [ADDR_W:0] FCS_LEN   = (ADDR_W+1)'(4);
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic              busy_q;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic              uc_q, uc_d, bc_q, bc_d;
    logic              uc_n, bc_n;
    logic              buf_we_q, buf_we_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_wdata_q, buf_wdata_d;
    logic              frm_valid_q, frm_valid_d;
    logic [ADDR_W:0]   frm_len_q, frm_len_d;
    logic              crc_err_q, crc_err_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              drop_inc, discard;
    logic              frame_start, frame_end;
    logic [7:0]        mac_byte;
    logic              crc_good;

`ifdef RMII_RX_CRC_CHECK_EN
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Running register over data+FCS lands on the fixed CRC-32 residue for a good frame.
    assign crc_good = (crc_q == 32'hDEBB20E3);
`else
    assign crc_good = 1'b1;
`endif

    assign frame_start = rx_busy & ~busy_q;
    assign frame_end   = ~rx_busy & busy_q;

    always_comb begin
        mac_byte = 8'h00;
        case (wr_ptr_q[2:0])
            3'd0:    mac_byte = MAC_ADDR[47:40];
            3'd1:    mac_byte = MAC_ADDR[39:32];
            3'd2:    mac_byte = MAC_ADDR[31:24];
            3'd3:    mac_byte = MAC_ADDR[23:16];
            3'd4:    mac_byte = MAC_ADDR[15:8];
            3'd5:    mac_byte = MAC_ADDR[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        uc_d        = uc_q;
        bc_d        = bc_q;
        uc_n        = uc_q;
        bc_n        = bc_q;
        buf_we_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        frm_valid_d = frm_valid_q;
        frm_len_d   = frm_len_q;
        crc_err_d   = 1'b0;
        drop_inc    = 1'b0;
        discard     = 1'b0;
`ifdef RMII_RX_CRC_CHECK_EN
        crc_d       = crc_q;
`endif

        if (frm_ack && frm_valid_q) frm_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    if (frm_valid_q) begin
                        state_d  = DISCARD;
                        drop_inc = 1'b1;
                    end else begin
                        state_d  = RECV;
                        wr_ptr_d = '0;
                        uc_d     = 1'b1;
                        bc_d     = 1'b1;
`ifdef RMII_RX_CRC_CHECK_EN
                        crc_d    = 32'hFFFFFFFF;
`endif
                    end
                end
            end
            RECV: begin
                if (rx_rdy) begin
                    if (wr_ptr_q == BUF_SIZE) begin
                        discard  = 1'b1;
                        drop_inc = 1'b1;
                    end else begin
                        buf_we_d    = 1'b1;
                        buf_addr_d  = wr_ptr_q[ADDR_W-1:0];
                        buf_wdata_d = rx_data;
                        wr_ptr_d    = wr_ptr_q + PTR_ONE;
`ifdef RMII_RX_CRC_CHECK_EN
                        crc_d       = crc_next(crc_q, rx_data);
`endif
                        if (wr_ptr_q < HDR_LEN) begin
                            uc_n = uc_q & (rx_data == mac_byte);
                            bc_n = bc_q & (rx_data == 8'hFF);
                            uc_d = uc_n;
                            bc_d = bc_n;
                            discard = ~uc_n & ~bc_n;
                        end
                    end
                end
                // A frame abandoned on its last byte has no end left to wait for.
                if (discard)        state_d = frame_end ? IDLE : DISCARD;
                else if (frame_end) state_d = CHECK;
            end
            CHECK: begin
                if ((wr_ptr_q >= MIN_LEN_W) && crc_good) begin
                    frm_valid_d = 1'b1;
                    frm_len_d   = wr_ptr_q - FCS_LEN;
                end else begin
                    crc_err_d = 1'b1;
                    drop_inc  = 1'b1;
                end
                state_d = IDLE;
            end
            DISCARD: begin
                if (frame_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        drop_cnt_d = (drop_inc && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            wr_ptr_q    <= '0;
            uc_q        <= 1'b0;
            bc_q        <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= 8'h00;
            frm_valid_q <= 1'b0;
            frm_len_q   <= '0;
            crc_err_q   <= 1'b0;
            drop_cnt_q  <= 8'h00;
`ifdef RMII_RX_CRC_CHECK_EN
            crc_q       <= 32'hFFFFFFFF;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= rx_busy;
            wr_ptr_q    <= wr_ptr_d;
            uc_q        <= uc_d;
            bc_q        <= bc_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            frm_valid_q <= frm_valid_d;
            frm_len_q   <= frm_len_d;
            crc_err_q   <= crc_err_d;
            drop_cnt_q  <= drop_cnt_d;
`ifdef RMII_RX_CRC_CHECK_EN
            crc_q       <= crc_d;
`endif
        end
    end

    assign buf_we    = buf_we_q;
    assign buf_addr  = buf_addr_q;
    assign buf_wdata = buf_wdata_q;
    assign frm_valid = frm_valid_q;
    assign frm_len   = frm_len_q;
    assign crc_err   = crc_err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rmii_rx_frame_ctrl.sv
// Scoreboard bench for rmii_rx_frame_ctrl: a frame-level model predicts buffer writes and verdicts,
// a separate monitor compares them as the DUT presents them.
module tb_rmii_rx_frame_ctrl;

    localparam int          ADDR_W    = 11;
    localparam logic [47:0] MAC       = 48'h02_00_00_00_00_01;
    localparam int          MIN_LEN   = 64;
    localparam int          BUF_BYTES = 1 << ADDR_W;

    typedef logic [7:0] byte_q_t[$];

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_rdy;
    logic              rx_busy;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_wdata;
    logic              frm_valid;
    logic [ADDR_W:0]   frm_len;
    logic              frm_ack;
    logic              crc_err;
    logic [7:0]        drop_cnt;

    int tests = 0;
    int fails = 0;

    int         exp_addr_q[$];
    logic [7:0] exp_data_q[$];
    int         exp_evt_q[$];   // accepted frm_len, or 0 for a rejected frame

    bit model_valid = 0;
    int model_drop  = 0;
    int model_len   = 0;

    always #5 clk = ~clk;

    rmii_rx_frame_ctrl #(.ADDR_W(ADDR_W), .MAC_ADDR(MAC), .MIN_LEN(MIN_LEN)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_busy(rx_busy),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .frm_valid(frm_valid), .frm_len(frm_len), .frm_ack(frm_ack),
        .crc_err(crc_err), .drop_cnt(drop_cnt)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] mac_byte(input int i);
        return MAC[47-8*i -: 8];
    endfunction

    function automatic logic [31:0] fcs32(input byte_q_t d, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, d[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // kind: 0 unicast to MAC, 1 broadcast, 2 unicast with byte miss_at corrupted
    function automatic byte_q_t build_frame(input int kind, input int n, input bit bad, input int miss_at);
        byte_q_t    f;
        logic [7:0] b;
        logic [31:0] fcs;
        int bi;
        for (int i = 0; i < n - 4; i++) begin
            if (i < 6) b = (kind == 1) ? 8'hFF : mac_byte(i);
            else       b = 8'($urandom);
            if (kind == 2 && i == miss_at) b = mac_byte(i) ^ 8'h03;
            f.push_back(b);
        end
        fcs = fcs32(f, n - 4);
        if (bad) begin
            bi = $urandom_range(0, 31);
            fcs[bi] = ~fcs[bi];
        end
        for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
        return f;
    endfunction

    function automatic void model_drop_inc();
        if (model_drop < 255) model_drop++;
    endfunction

    // Frame-level prediction: what lands in the buffer and what verdict follows.
    function automatic void predict(input byte_q_t f);
        int n, nwr;
        bit uc, bc, miss, good;
        n = f.size();
        uc = 1; bc = 1; miss = 0; nwr = n;
        for (int i = 0; i < 6 && i < n; i++) begin
            uc = uc && (f[i] == mac_byte(i));
            bc = bc && (f[i] == 8'hFF);
            if (!uc && !bc) begin
                miss = 1;
                nwr  = i + 1;
                break;
            end
        end
        if (!miss && n > BUF_BYTES) begin
            nwr = BUF_BYTES;
            model_drop_inc();
        end
        for (int i = 0; i < nwr; i++) begin
            exp_addr_q.push_back(i);
            exp_data_q.push_back(f[i]);
        end
        if (!miss && n <= BUF_BYTES) begin
            good = (n >= MIN_LEN);
`ifdef RMII_RX_CRC_CHECK_EN
            good = good && (fcs32(f, n - 4) == {f[n-1], f[n-2], f[n-3], f[n-4]});
`endif
            if (good) begin
                exp_evt_q.push_back(n - 4);
                model_valid = 1;
                model_len   = n - 4;
            end else begin
                exp_evt_q.push_back(0);
                model_drop_inc();
            end
        end
    endfunction

    task automatic send_frame(input byte_q_t f, input bit ack_at_start, input bit end_with_last);
        int gap;
        if (model_valid) begin
            model_drop_inc();
            if (ack_at_start) model_valid = 0;
        end else begin
            predict(f);
        end
        @(negedge clk);
        rx_busy = 1'b1;
        frm_ack = ack_at_start;
        @(negedge clk);
        frm_ack = 1'b0;
        @(negedge clk);
        for (int i = 0; i < f.size(); i++) begin
            rx_data = f[i];
            rx_rdy  = 1'b1;
            if (end_with_last && i == f.size() - 1) rx_busy = 1'b0;
            @(negedge clk);
            rx_rdy = 1'b0;
            gap = (f.size() > 256) ? 0 : $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
        end
        rx_busy = 1'b0;
        repeat (6) @(negedge clk);
        check("drop_cnt", drop_cnt, model_drop);
        check("frm_valid", frm_valid, model_valid);
    endtask

    task automatic do_ack();
        @(negedge clk);
        frm_ack = 1'b1;
        @(negedge clk);
        frm_ack = 1'b0;
        model_valid = 0;
        check("frm_valid_after_ack", frm_valid, 0);
        check("frm_len_after_ack", frm_len, model_len);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_buf_we"}, buf_we, 0);
        check({tag, "_buf_addr"}, buf_addr, 0);
        check({tag, "_buf_wdata"}, buf_wdata, 0);
        check({tag, "_frm_valid"}, frm_valid, 0);
        check({tag, "_frm_len"}, frm_len, 0);
        check({tag, "_crc_err"}, crc_err, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a write, a verdict or a held frame.
    initial begin
        int         e;
        int         a;
        logic [7:0] d;
        logic [63:0] cur_len;
        bit         prev_valid;
        prev_valid = 0;
        cur_len    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_valid = 0;
            end else begin
                if (buf_we) begin
                    if (exp_addr_q.size() == 0) check("write_expected", buf_we, 0);
                    else begin
                        a = exp_addr_q.pop_front();
                        d = exp_data_q.pop_front();
                        check("buf_addr", buf_addr, a);
                        check("buf_wdata", buf_wdata, d);
                    end
                end
                if (crc_err) begin
                    if (exp_evt_q.size() == 0) check("crc_err_expected", crc_err, 0);
                    else begin
                        e = exp_evt_q.pop_front();
                        check("reject_event", e, 0);
                    end
                end
                if (frm_valid && !prev_valid) begin
                    if (exp_evt_q.size() == 0) check("frm_valid_rise_expected", frm_valid, 0);
                    else begin
                        e = exp_evt_q.pop_front();
                        cur_len = e;
                        check("frm_len", frm_len, e);
                    end
                end else if (frm_valid && prev_valid) begin
                    check("frm_len_hold", frm_len, cur_len);
                end
                prev_valid = frm_valid;
            end
        end
    end

    initial begin
        byte_q_t f;
        int kind;
        rst = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0; rx_busy = 1'b0; frm_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // good 64-byte unicast frame, then bad FCS
        send_frame(build_frame(0, 64, 0, 0), 0, 0);
        check("frm_len_60", frm_len, 60);
        do_ack();
        send_frame(build_frame(0, 64, 1, 0), 0, 0);
        if (model_valid) do_ack();

        // address filter miss at the last byte, then broadcast accepted
        send_frame(build_frame(2, 80, 0, 5), 0, 0);
        send_frame(build_frame(1, 70, 0, 0), 0, 1);

        // buffer held: drop, drop with simultaneous ack, then accept again
        send_frame(build_frame(0, 90, 0, 0), 0, 0);
        send_frame(build_frame(0, 72, 0, 0), 1, 0);
        send_frame(build_frame(0, 66, 0, 0), 0, 1);
        do_ack();

        // short frame, overflow, exact-fit frame
        send_frame(build_frame(0, 40, 0, 0), 0, 0);
        send_frame(build_frame(0, BUF_BYTES + 5, 0, 0), 0, 0);
        send_frame(build_frame(0, BUF_BYTES, 0, 0), 0, 1);
        do_ack();

        for (int t = 0; t < 25; t++) begin
            if (model_valid && $urandom_range(0, 1) == 1) do_ack();
            kind = $urandom_range(0, 2);
            f = build_frame(kind, $urandom_range(10, 150), $urandom_range(0, 3) == 0, $urandom_range(0, 5));
            send_frame(f, model_valid && ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
        end

        // drop counter saturation
        if (!model_valid) send_frame(build_frame(0, 64, 0, 0), 0, 0);
        for (int t = 0; t < 260; t++) send_frame(build_frame(0, 10, 0, 0), 0, $urandom_range(0, 1) == 1);
        check("drop_cnt_sat", drop_cnt, 255);
        do_ack();

        // reset at byte 30 of a frame, then a clean frame
        f = build_frame(0, 80, 0, 0);
        @(negedge clk);
        rx_busy = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            exp_addr_q.push_back(i);
            exp_data_q.push_back(f[i]);
            rx_data = f[i];
            rx_rdy  = 1'b1;
            @(negedge clk);
            rx_rdy = 1'b0;
        end
        rst = 1'b1;
        rx_busy = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midreset");
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_evt_q.delete();
        model_valid = 0; model_drop = 0; model_len = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(build_frame(0, 100, 0, 0), 0, 0);
        check("frm_len_after_reset", frm_len, 96);

        repeat (10) @(negedge clk);
        check("pending_writes", exp_addr_q.size(), 0);
        check("pending_events", exp_evt_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
